// File: rtl/pipeline_controller.sv
// Hazard, branch and SRAM-stall controller for a five-stage pipeline.
// Mealy control outputs, sticky SRAM timeout, saturating stall/flush statistics.
module pipeline_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_detected,
    input  logic        br_taken,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic        sram_ready,
    output logic        freeze_front,
    output logic        flush_if_id,
    output logic        bubble_id_exe,
    output logic        freeze_back,
    output logic        sram_req,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_RUN      = 2'b01,
        S_MEM_WAIT = 2'b10,
        S_ERROR    = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;
    logic        timeout_q, timeout_d;
    logic        mem_access;

    assign mem_access = mem_r_en | mem_w_en;

    // NOTE: every signal gets its default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        timeout_d     = timeout_q;
        freeze_front  = 1'b0;
        flush_if_id   = 1'b0;
        bubble_id_exe = 1'b0;
        freeze_back   = 1'b0;
        sram_req      = 1'b0;

        case (state_q)
            S_IDLE: begin
                freeze_front  = 1'b1;
                bubble_id_exe = 1'b1;
                state_d       = S_RUN;
            end
            S_RUN: begin
                sram_req = mem_access;
                // A memory stall outranks hazards, and a hazard outranks a branch.
                if (mem_access && !sram_ready) begin
                    freeze_front = 1'b1;
                    freeze_back  = 1'b1;
                    wait_d       = 8'd0;
                    state_d      = S_MEM_WAIT;
                end else if (hazard_detected) begin
                    freeze_front  = 1'b1;
                    bubble_id_exe = 1'b1;
                end else if (br_taken) begin
                    flush_if_id = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                sram_req = 1'b1;
                if (!sram_ready) begin
                    freeze_front = 1'b1;
                    freeze_back  = 1'b1;
                    if (wait_q == 8'hFF) begin
                        state_d   = S_ERROR;
                        timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                freeze_front  = 1'b1;
                bubble_id_exe = 1'b1;
                freeze_back   = 1'b1;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if ((state_q == S_RUN || state_q == S_MEM_WAIT) && freeze_front && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
        if (flush_if_id && flush_q != 16'hFFFF)
            flush_d = flush_q + 16'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wait_q    <= 8'd0;
            stall_q   <= 16'd0;
            flush_q   <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            timeout_q <= timeout_d;
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
    assign mem_timeout  = timeout_q;

endmodule
